memd_responder: RTL

MEMD_RESPONDER -- requirements
Module: memd_responder

---
 rtl/memd_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/memd_responder.sv
// rtl/memd_responder.sv - in-order read responder with fixed-latency word memory
`ifndef MEMD_SIZE_LOG
`define MEMD_SIZE_LOG 4
`endif
`ifndef REG_LEN
`define REG_LEN 8
`endif

module memd_responder #(
    parameter int MEMD_SIZE_LOG = `MEMD_SIZE_LOG,
    parameter int REG_LEN       = `REG_LEN,
    parameter int LATENCY       = 2,
    parameter int QDEPTH_LOG    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [MEMD_SIZE_LOG-1:0] req_addr,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [REG_LEN-1:0]       resp_data,
    input  logic                     wr_en,
    input  logic [MEMD_SIZE_LOG-1:0] wr_addr,
    input  logic [REG_LEN-1:0]       wr_data,
    output logic                     busy
);

    localparam int                  DEPTH     = 1 << QDEPTH_LOG;
    localparam int                  WORDS     = 1 << MEMD_SIZE_LOG;
    localparam logic [QDEPTH_LOG:0] DEPTH_CNT = (QDEPTH_LOG + 1)'(DEPTH);
    localparam logic [3:0]          CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                   state;
    logic [3:0]               cnt;
    logic [REG_LEN-1:0]       resp_data_r;
    logic                     resp_valid_r;

    logic [MEMD_SIZE_LOG-1:0] addr_q [DEPTH];
    logic [QDEPTH_LOG-1:0]    head;
    logic [QDEPTH_LOG-1:0]    tail;
    logic [QDEPTH_LOG:0]      occ;

    logic [REG_LEN-1:0]       mem [WORDS];

    logic                     full;
    logic                     push;
    logic                     pop;

    // Handshake decodes; ready depends only on registered occupancy, so a
    // pop on a full queue cannot let a push through on the same edge.
    always_comb begin
        full       = (occ == DEPTH_CNT);
        req_ready  = !full;
        push       = req_valid && !full;
        pop        = resp_valid_r && resp_ready;
        resp_valid = resp_valid_r;
        resp_data  = resp_data_r;
        busy       = (occ != '0) || (state != ST_IDLE);
    end

    // Word array: plain write port, never reset so preloaded data survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Request address storage; only the slot at the tail is written on a push.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            addr_q[tail] <= req_addr;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Service FSM: wait out the latency, latch the head word, hold it until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            resp_data_r  <= '0;
            resp_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (occ != '0) begin
                        state <= ST_WAIT;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state        <= ST_RESP;
                        resp_valid_r <= 1'b1;
                        // Sampled before this edge's write lands: a same-edge
                        // write to this address returns the old word.
                        resp_data_r  <= mem[addr_q[head]];
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state        <= ST_IDLE;
                        resp_valid_r <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    resp_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
